// File: rtl/ascon_hash_sequencer.sv
// Control sequencer for the Ascon-Hash datapath: IV load, initial permutation,
// length-driven absorb with padding, and NSQ-block tag squeeze.
module ascon_hash_sequencer #(
  parameter int BW    = 64,
  parameter int LEN_W = 8,
  parameter int NSQ   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] m_length,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             dp_load_iv,
  output logic             dp_absorb,
  output logic [3:0]       dp_absorb_bytes,
  output logic             dp_squeeze,
  output logic [1:0]       dp_sq_idx,
  output logic             busy,
  output logic             done
);

  // Word/absorb counters reach 2^(LEN_W-3), hence LEN_W-2 bits.
  localparam int CW = LEN_W - 2;
  localparam logic [3:0] FULL_BYTES = 4'(BW / 8);
  localparam logic [1:0] SQ_LAST    = 2'(NSQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADIV, S_PSTART, S_PWAIT, S_ABS, S_SQ, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_INIT, PH_ABS, PH_SQ
  } phase_t;

  state_t        state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [CW-1:0] words_left_reg, words_left_next;
  logic [CW-1:0] abs_left_reg, abs_left_next;
  logic [2:0]    rem_reg, rem_next;
  logic [1:0]    sq_idx_reg, sq_idx_next;

  logic [LEN_W:0] len_plus7;
  logic [CW-1:0]  words_calc;
  logic [CW-1:0]  abs_calc;

  assign len_plus7  = {1'b0, m_length} + (LEN_W+1)'(7);
  assign words_calc = len_plus7[LEN_W:3];
  assign abs_calc   = {1'b0, m_length[LEN_W-1:3]} + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      phase_reg      <= PH_INIT;
      words_left_reg <= '0;
      abs_left_reg   <= '0;
      rem_reg        <= '0;
      sq_idx_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      words_left_reg <= words_left_next;
      abs_left_reg   <= abs_left_next;
      rem_reg        <= rem_next;
      sq_idx_reg     <= sq_idx_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    words_left_next = words_left_reg;
    abs_left_next   = abs_left_reg;
    rem_next        = rem_reg;
    sq_idx_next     = sq_idx_reg;
    blk_ready       = 1'b0;
    perm_start      = 1'b0;
    dp_load_iv      = 1'b0;
    dp_absorb       = 1'b0;
    dp_absorb_bytes = 4'd0;
    dp_squeeze      = 1'b0;
    dp_sq_idx       = 2'd0;
    busy            = 1'b1;
    done            = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          words_left_next = words_calc;
          abs_left_next   = abs_calc;
          rem_next        = m_length[2:0];
          sq_idx_next     = 2'd0;
          state_next      = S_LOADIV;
        end
      end

      S_LOADIV: begin
        dp_load_iv = 1'b1;
        phase_next = PH_INIT;
        state_next = S_PSTART;
      end

      S_PSTART: begin
        perm_start = 1'b1;
        state_next = S_PWAIT;
      end

      S_PWAIT: begin
        if (perm_done) begin
          case (phase_reg)
            PH_INIT: state_next = S_ABS;
            PH_ABS: begin
              if (abs_left_reg == '0) begin
                sq_idx_next = 2'd0;
                state_next  = S_SQ;
              end else begin
                state_next  = S_ABS;
              end
            end
            default: state_next = S_SQ;
          endcase
        end
      end

      S_ABS: begin
        phase_next = PH_ABS;
        if (words_left_reg != '0) begin
          blk_ready = 1'b1;
          if (blk_valid) begin
            dp_absorb       = 1'b1;
            dp_absorb_bytes = (words_left_reg == CW'(1) && rem_reg != 3'd0) ?
                              {1'b0, rem_reg} : FULL_BYTES;
            words_left_next = words_left_reg - CW'(1);
            abs_left_next   = abs_left_reg - CW'(1);
            state_next      = S_PSTART;
          end
        end else begin
          // Length was a multiple of 8: an extra block carrying only the pad.
          dp_absorb     = 1'b1;
          abs_left_next = abs_left_reg - CW'(1);
          state_next    = S_PSTART;
        end
      end

      S_SQ: begin
        dp_squeeze = 1'b1;
        dp_sq_idx  = sq_idx_reg;
        phase_next = PH_SQ;
        if (sq_idx_reg != SQ_LAST) begin
          sq_idx_next = sq_idx_reg + 2'd1;
          state_next  = S_PSTART;
        end else begin
          state_next  = S_FIN;
        end
      end

      S_FIN: begin
        done       = 1'b1;
        busy       = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_hash_sequencer.sv
// Bench for ascon_hash_sequencer: table-driven and random-length hashes checked
// against an arithmetic model of the absorb/squeeze schedule.
module tb_ascon_hash_sequencer;

  localparam int PLAT = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] m_length;
  logic       blk_valid;
  logic       blk_ready;
  logic       perm_start;
  logic       perm_done;
  logic       dp_load_iv;
  logic       dp_absorb;
  logic [3:0] dp_absorb_bytes;
  logic       dp_squeeze;
  logic [1:0] dp_sq_idx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;
  int pcnt     = 0;

  always #5 clk = ~clk;

  ascon_hash_sequencer #(.BW(64), .LEN_W(8), .NSQ(4)) dut (
    .clk(clk), .rst(rst), .start(start), .m_length(m_length),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .perm_start(perm_start), .perm_done(perm_done),
    .dp_load_iv(dp_load_iv), .dp_absorb(dp_absorb),
    .dp_absorb_bytes(dp_absorb_bytes), .dp_squeeze(dp_squeeze),
    .dp_sq_idx(dp_sq_idx), .busy(busy), .done(done)
  );

  typedef struct {
    int len;
    int gap;
    bit rand_gap;
    bit poke;
    int exp_hs;
    int exp_perms;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int any_out();
    return int'(blk_ready) + int'(perm_start) + int'(dp_load_iv) + int'(dp_absorb) +
           int'(dp_absorb_bytes) + int'(dp_squeeze) + int'(dp_sq_idx) +
           int'(busy) + int'(done);
  endfunction

  // Runs one hash with a latency-PLAT permutation model and a gapped upstream.
  // rst_at > 0 aborts with reset during the PWAIT following absorb number rst_at.
  task automatic run_hash(input int len, input int gap, input bit rand_gap,
                          input bit poke, input int rst_at,
                          input int exp_hs, input int exp_ps);
    int abs_q[$], sq_q[$], exp_abs[$];
    int hs = 0, ps = 0, dn = 0, inv = 0, waits = 0, exp_waits = 0;
    int words_sent = 0, gap_left, nw, cyc = 0, rst_cd = 0, bad, first_busy = 0;
    bit s_hs, s_ready, s_ps, finished = 0, aborted = 0, poked = 0;

    nw = (len + 7) / 8;
    for (int i = 0; i < len / 8; i++) exp_abs.push_back(8);
    exp_abs.push_back(len % 8);

    @(posedge clk); #1;
    start = 1'b1; m_length = 8'(len); blk_valid = 1'b0;
    gap_left = rand_gap ? int'($urandom_range(0, 3)) : gap;
    if (nw > 0) exp_waits = gap_left;
    if (nw > 0 && gap_left == 0) blk_valid = 1'b1;

    while (!finished && !aborted) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) first_busy = int'(busy);
      s_hs = blk_valid && blk_ready;
      s_ready = blk_ready;
      s_ps = perm_start;
      if (s_hs) hs++;
      if (perm_start) ps++;
      if (blk_ready && !blk_valid) waits++;
      if (int'(dp_load_iv) + int'(dp_absorb) + int'(dp_squeeze) + int'(perm_start) > 1) inv++;
      if (blk_ready && !busy) inv++;
      if (dp_absorb && dp_absorb_bytes != 4'd0 && !s_hs) inv++;
      if (dp_absorb && dp_absorb_bytes == 4'd0 && blk_ready) inv++;
      if (done && busy) inv++;
      if (dp_absorb) abs_q.push_back(int'(dp_absorb_bytes));
      if (dp_squeeze) sq_q.push_back(int'(dp_sq_idx));
      if (done) begin dn++; finished = 1; end
      if (rst_at > 0 && abs_q.size() == rst_at && perm_start) rst_cd = 3;
      if (cyc > 4000) begin
        check("timeout", cyc, 4000);
        aborted = 1;
      end

      @(posedge clk); #1;
      start = 1'b0;
      if (poke && !poked && dp_absorb) begin
        start = 1'b1; m_length = 8'd200; poked = 1;
      end
      perm_done = 1'b0;
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) perm_done = 1'b1;
      end
      if (s_ps) pcnt = PLAT;
      if (s_hs) begin
        words_sent++;
        blk_valid = 1'b0;
        if (words_sent < nw) begin
          gap_left = rand_gap ? int'($urandom_range(0, 3)) : gap;
          exp_waits += gap_left;
        end
      end else if (s_ready && !blk_valid && gap_left > 0) begin
        gap_left--;
      end
      if (!blk_valid && words_sent < nw && gap_left == 0) blk_valid = 1'b1;
      if (rst_cd > 0) begin
        rst_cd--;
        if (rst_cd == 0) begin rst = 1'b1; aborted = 1; end
      end
    end

    if (rst_at > 0) begin
      @(posedge clk); #1;
      rst = 1'b0; perm_done = 1'b1; pcnt = 0; blk_valid = 1'b0;
      @(posedge clk); #1;
      perm_done = 1'b0;
      return;
    end

    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("L%0d busy_after_done", len), int'(busy) + int'(done), 0);
    check($sformatf("L%0d busy_after_start", len), first_busy, 1);
    check($sformatf("L%0d handshakes", len), hs, exp_hs);
    check($sformatf("L%0d perm_starts", len), ps, exp_ps);
    check($sformatf("L%0d done_pulses", len), dn, 1);
    check($sformatf("L%0d invariant_errs", len), inv, 0);
    check($sformatf("L%0d ready_wait_cycles", len), waits, exp_waits);
    check($sformatf("L%0d absorb_count", len), abs_q.size(), exp_abs.size());
    bad = -1;
    for (int i = 0; i < abs_q.size() && i < exp_abs.size(); i++)
      if (bad < 0 && abs_q[i] != exp_abs[i]) bad = i;
    check($sformatf("L%0d absorb_bytes_bad_idx", len), bad, -1);
    check($sformatf("L%0d squeeze_count", len), sq_q.size(), 4);
    bad = -1;
    for (int i = 0; i < sq_q.size(); i++)
      if (bad < 0 && sq_q[i] != i) bad = i;
    check($sformatf("L%0d squeeze_idx_bad_idx", len), bad, -1);
    $display("hash L=%0d gap=%0d hs=%0d perms=%0d absorbs=%0d squeezes=%0d",
             len, gap, hs, ps, abs_q.size(), sq_q.size());
  endtask

  initial begin
    vec_t vecs[7];
    int bad, len;

    vecs[0] = '{len: 0,   gap: 0, rand_gap: 0, poke: 0, exp_hs: 0,  exp_perms: 5};
    vecs[1] = '{len: 13,  gap: 0, rand_gap: 0, poke: 0, exp_hs: 2,  exp_perms: 6};
    vecs[2] = '{len: 16,  gap: 0, rand_gap: 0, poke: 0, exp_hs: 2,  exp_perms: 7};
    vecs[3] = '{len: 24,  gap: 5, rand_gap: 0, poke: 0, exp_hs: 3,  exp_perms: 8};
    vecs[4] = '{len: 13,  gap: 1, rand_gap: 0, poke: 1, exp_hs: 2,  exp_perms: 6};
    vecs[5] = '{len: 255, gap: 0, rand_gap: 0, poke: 0, exp_hs: 32, exp_perms: 36};
    vecs[6] = '{len: 8,   gap: 2, rand_gap: 0, poke: 0, exp_hs: 1,  exp_perms: 6};

    rst = 1'b1; start = 1'b0; m_length = 8'd0; blk_valid = 1'b0; perm_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", any_out(), 0);

    for (int i = 0; i < 7; i++)
      run_hash(vecs[i].len, vecs[i].gap, vecs[i].rand_gap, vecs[i].poke, 0,
               vecs[i].exp_hs, vecs[i].exp_perms);

    // Reset during PWAIT of the second absorb, followed by a stray perm_done.
    run_hash(24, 0, 0, 0, 2, 0, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bad += any_out();
    end
    check("reset_midhash_quiet", bad, 0);
    $display("reset mid-hash: quiet-window output activity=%0d", bad);
    run_hash(8, 0, 0, 0, 0, 1, 6);

    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(0, 255));
      run_hash(len, 0, 1, 0, 0, (len + 7) / 8, 1 + (len / 8 + 1) + 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascon_hash_sequencer.md
Name: ascon_hash_sequencer

Overview:
- Control FSM that sequences the Ascon-Hash datapath through its phases: IV load, initial permutation, message absorb, padding, and 4-block tag squeeze.
- Drives the permutation engine through a start/done handshake.
- Accepts message words from upstream over a valid/ready stream and emits one-cycle strobes to the datapath.
- Replaces the fixed-sequence controller and adds backpressure, length-driven padding and busy/done status.

Parameters:
- BW, 64, datapath word width (one rate block); informational for the block_in width in the datapath.
- LEN_W, 8, width of message byte-length input.
- NSQ, 4, number of squeezed tag blocks (4 x 64 = 256-bit tag).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to hash a message; honoured only in IDLE
- m_length  in  LEN_W  message length in bytes; sampled on accepted start
- blk_valid  in  1  upstream has a message word on block_in (datapath-side bus)
- blk_ready  out  1  sequencer accepts the word this cycle
- perm_start  out  1  one-cycle pulse that launches a 12-round permutation
- perm_done  in  1  one-cycle pulse from the permutation engine at completion
- dp_load_iv  out  1  datapath loads the IV into the state
- dp_absorb  out  1  datapath XORs the padded block into x0 this cycle
- dp_absorb_bytes  out  4  valid message bytes in the absorbed block; 8 = full block, no pad; 0..7 = final block, pad byte at index n
- dp_squeeze  out  1  datapath captures x0 into tag slot dp_sq_idx
- dp_sq_idx  out  2  tag slot index, 0..NSQ-1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse: tag complete

Behaviour:
- Reset (rst=1 at edge): state IDLE; all outputs 0; counters cleared. Applies in any state, including mid-hash; an in-flight perm_done after reset is ignored.
- Length derivation, latched on start:
  - W = ceil(L/8) input words.
  - R = L mod 8.
  - Total absorbs A = floor(L/8)+1.
- States:
  - IDLE: on start, latch L, go to LOADIV.
  - LOADIV: dp_load_iv=1 for 1 cycle, go to PSTART.
  - PSTART: perm_start=1 for 1 cycle, go to PWAIT.
  - PWAIT: hold until perm_done=1, then go to the successor recorded by phase: INIT→ABS, ABS→ABS or SQ, SQ→SQ.
  - ABS:
    - If words_left>0: blk_ready=1. Handshake (blk_valid&blk_ready) asserts dp_absorb the same cycle. dp_absorb_bytes = 8, except for the last word with R≠0, which gives R. Decrement words_left, go to PSTART.
    - If words_left=0 and a pad-only block is still owed (R=0): dp_absorb=1, dp_absorb_bytes=0, blk_ready=0, go to PSTART.
    - After the final absorb's permutation completes, go to SQ with sq_idx=0.
  - SQ: dp_squeeze=1, dp_sq_idx=sq_idx for 1 cycle. If sq_idx<NSQ-1: increment, go to PSTART. Else go to FIN.
  - FIN: done=1 for 1 cycle, busy drops the same cycle, go to IDLE.
- Handshake rules:
  - blk_ready is 0 outside ABS.
  - blk_valid without ready is held by upstream; no word is dropped or double-consumed.
  - perm_done outside PWAIT is ignored, as is perm_done coinciding with perm_start.
  - start while busy is ignored, and m_length is not re-sampled.
- Permutation count per hash = 1 + A + (NSQ-1).
- Datapath strobes are mutually exclusive; at most one of dp_load_iv/dp_absorb/dp_squeeze/perm_start is high per cycle.
- L=0 is legal: zero words consumed, one pad-only absorb.
- L=255 gives W=32, R=7, A=32.

Test Plan:
- L=0, permutation model done 12 cycles after start:
  - 0 handshakes; one dp_absorb with bytes=0.
  - 5 perm_start pulses; 4 dp_squeeze with idx 0,1,2,3; done once.
- L=13:
  - 2 handshakes, absorb bytes 8 then 5.
  - 6 perm_start pulses; no pad-only absorb; done once, busy low after.
- L=16:
  - absorb bytes 8, 8, then pad-only 0 with blk_ready=0.
  - 7 perm_start pulses total.
- Backpressure, L=24, blk_valid low for 5 cycles before each word:
  - blk_ready holds high while waiting; exactly 3 handshakes; no dp_absorb without a handshake (except the pad-only).
- start pulsed while busy during absorb:
  - ignored; sequence and counts unchanged; m_length change mid-hash has no effect.
- rst asserted during PWAIT of the second absorb, then stray perm_done next cycle:
  - all outputs 0, state IDLE, no perm_start follows.
  - a new start with L=8 then completes normally: 2 absorbs, 6 perms.
